// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types and constants for the 4x4 hex keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_KEYS = 16;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef logic [3:0] key_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_t;

  // Physical position (row*4 + col) to CHIP-8 key, rows: 123C / 456D / 789E / A0BF
  localparam key_idx_t REMAP_TABLE [NUM_KEYS] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : One debounced key bit; flips after DEBOUNCE_SCANS agreeing samples.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic sample_en,
  output logic debounced,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          db_q, db_d;

  always_comb begin
    cnt_inc = cnt_q + CW'(1);
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise    = 1'b0;
    if (sample_en) begin
      if (sample == db_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
        db_d  = ~db_q;
        cnt_d = '0;
        rise  = sample;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign debounced = db_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with per-key debounce and press events.
//            Define KEYPAD_REMAP_EN to translate positions to the CHIP-8 layout.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                fpga_clk,
  input  logic                rst_in,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [NUM_KEYS-1:0] keymap,
  output logic                key_event,
  output key_idx_t            key_index,
  output logic                scan_done
);

  localparam int SW = $clog2(SETTLE_CYCLES);

  function automatic key_idx_t phys_to_key(input int p);
`ifdef KEYPAD_REMAP_EN
    return REMAP_TABLE[p];
`else
    return key_idx_t'(p);
`endif
  endfunction

  scan_state_t         state_q, state_d;
  logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic                key_event_q, key_event_d;
  key_idx_t            key_index_q, key_index_d;
  logic                scan_done_q, scan_done_d;

  logic [NUM_KEYS-1:0] db_phys, rise_phys;
  logic [NUM_KEYS-1:0] keymap_w, rise_map;
  logic                sample_phase;

  assign sample_phase = (state_q == SAMPLE);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    col_idx_d    = col_idx_q;
    col_d        = col_q;
    scan_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
        col_d        = ~(4'b0001 << col_idx_q);
      end
      SETTLE: begin
        if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d      = SAMPLE;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      SAMPLE: begin
        col_idx_d   = col_idx_q + 2'd1;
        col_d       = ~(4'b0001 << col_idx_d);
        scan_done_d = (col_idx_q == 2'd3);
        state_d     = SETTLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge fpga_clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      col_idx_q    <= '0;
      col_q        <= 4'b1111;
      row_meta_q   <= 4'b1111;
      row_sync_q   <= 4'b1111;
      key_event_q  <= 1'b0;
      key_index_q  <= '0;
      scan_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      row_meta_q   <= row;
      row_sync_q   <= row_meta_q;
      key_event_q  <= key_event_d;
      key_index_q  <= key_index_d;
      scan_done_q  <= scan_done_d;
    end
  end

  // Cells are indexed by physical position; rows are active-low
  for (genvar p = 0; p < NUM_KEYS; p++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk      (fpga_clk),
      .rst_n    (rst_in),
      .sample   (~row_sync_q[p / NUM_COLS]),
      .sample_en(sample_phase && (col_idx_q == 2'(p % NUM_COLS))),
      .debounced(db_phys[p]),
      .rise     (rise_phys[p])
    );
  end

  always_comb begin
    keymap_w = '0;
    rise_map = '0;
    for (int p = 0; p < NUM_KEYS; p++) begin
      keymap_w[phys_to_key(p)] = db_phys[p];
      rise_map[phys_to_key(p)] = rise_phys[p];
    end
  end

  // Descending scan so the lowest keymap bit wins
  always_comb begin
    key_event_d = |rise_map;
    key_index_d = key_index_q;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rise_map[k]) key_index_d = key_idx_t'(k);
    end
  end

  assign col       = col_q;
  assign keymap    = keymap_w;
  assign key_event = key_event_q;
  assign key_index = key_index_q;
  assign scan_done = scan_done_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Directed self-checking bench for keypad_scanner with a keypad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  logic        fpga_clk;
  logic        rst_in;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keymap;
  logic        key_event;
  logic [3:0]  key_index;
  logic        scan_done;

  logic [15:0] pressed;
  int          n;
  int          ev_cnt;
  int          errors;
  int          checks;

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // Physical keypad: key p pulls row p/4 low while column p%4 is driven low
  always_comb begin
    row = 4'b1111;
    for (int p = 0; p < 16; p++) begin
      if (pressed[p] && !col[p % 4]) row[p / 4] = 1'b0;
    end
  end

  keypad_scanner dut (
    .fpga_clk (fpga_clk),
    .rst_in   (rst_in),
    .row      (row),
    .col      (col),
    .keymap   (keymap),
    .key_event(key_event),
    .key_index(key_index),
    .scan_done(scan_done)
  );

  task automatic tick();
    @(posedge fpga_clk);
    #1;
    n++;
    if (key_event === 1'b1) ev_cnt++;
  endtask

  task automatic run_to(input int t);
    while (n < t) tick();
  endtask

  task automatic restart();
    rst_in = 1'b0;
    @(posedge fpga_clk);
    #1;
    rst_in = 1'b1;
    n      = 0;
    ev_cnt = 0;
  endtask

  task automatic test_reset();
    pressed = 16'h0000;
    rst_in  = 1'b1;
    #2;
    rst_in = 1'b0;
    repeat (3) @(posedge fpga_clk);
    #1;
    checks++;
    if (col !== 4'b1111) begin errors++; $display("FAIL reset_col got=%b exp=1111", col); end
    checks++;
    if (keymap !== 16'h0000) begin errors++; $display("FAIL reset_keymap got=%h exp=0000", keymap); end
    checks++;
    if (key_event !== 1'b0 || scan_done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got ev=%b sd=%b exp=0 0", key_event, scan_done);
    end
    checks++;
    if (key_index !== 4'd0) begin errors++; $display("FAIL reset_key_index got=%0d exp=0", key_index); end
    rst_in = 1'b1;
    n      = 0;
    ev_cnt = 0;
    checks++;
    if (col !== 4'b1111) begin errors++; $display("FAIL idle_col got=%b exp=1111", col); end
    tick();
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL first_col got=%b exp=1110", col); end
  endtask

  task automatic test_idle_scan();
    logic [3:0] one;
    logic [3:0] exp_col;
    logic       exp_sd;
    one = 4'b0001;
    while (n < 140) begin
      tick();
      exp_col = ~(one << (((n - 1) / 17) % 4));
      exp_sd  = (n > 1) && (((n - 1) % 68) == 0);
      checks++;
      if (col !== exp_col) begin errors++; $display("FAIL scan_col n=%0d got=%b exp=%b", n, col, exp_col); end
      checks++;
      if (scan_done !== exp_sd) begin errors++; $display("FAIL scan_done n=%0d got=%b exp=%b", n, scan_done, exp_sd); end
    end
    checks++;
    if (keymap !== 16'h0000 || ev_cnt != 0) begin
      errors++; $display("FAIL idle_keys got keymap=%h events=%0d exp=0000 0", keymap, ev_cnt);
    end
  endtask

  task automatic test_steady_press();
    pressed = 16'h0040;
    restart();
    run_to(255);
    checks++;
    if (keymap !== 16'h0000) begin errors++; $display("FAIL steady_early got=%h exp=0000", keymap); end
    run_to(256);
    checks++;
    if (keymap !== 16'h0040) begin errors++; $display("FAIL steady_keymap got=%h exp=0040", keymap); end
    checks++;
    if (key_event !== 1'b1 || key_index !== 4'd6) begin
      errors++; $display("FAIL steady_event got ev=%b idx=%0d exp=1 6", key_event, key_index);
    end
    tick();
    checks++;
    if (key_event !== 1'b0) begin errors++; $display("FAIL steady_pulse_width got=%b exp=0", key_event); end
    run_to(300);
    checks++;
    if (ev_cnt != 1 || key_index !== 4'd6) begin
      errors++; $display("FAIL steady_event_count got=%0d idx=%0d exp=1 6", ev_cnt, key_index);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b1111_0101;
    pressed = pat[0] ? 16'h0040 : 16'h0000;
    restart();
    for (int k = 1; k < 8; k++) begin
      run_to(68 * k);
      pressed = pat[k] ? 16'h0040 : 16'h0000;
    end
    run_to(527);
    checks++;
    if (keymap !== 16'h0000) begin errors++; $display("FAIL bounce_early got=%h exp=0000", keymap); end
    run_to(528);
    checks++;
    if (keymap !== 16'h0040 || key_event !== 1'b1) begin
      errors++; $display("FAIL bounce_flip got keymap=%h ev=%b exp=0040 1", keymap, key_event);
    end
    run_to(540);
    checks++;
    if (ev_cnt != 1) begin errors++; $display("FAIL bounce_event_count got=%0d exp=1", ev_cnt); end
  endtask

  task automatic test_two_keys();
    pressed = 16'h0088;
    restart();
    run_to(272);
    checks++;
    if (keymap !== 16'h0000) begin errors++; $display("FAIL two_early got=%h exp=0000", keymap); end
    run_to(273);
    checks++;
    if (keymap !== 16'h0088) begin errors++; $display("FAIL two_keymap got=%h exp=0088", keymap); end
    checks++;
    if (key_event !== 1'b1 || key_index !== 4'd3) begin
      errors++; $display("FAIL two_event got ev=%b idx=%0d exp=1 3", key_event, key_index);
    end
    pressed = 16'h0000;
    run_to(544);
    checks++;
    if (keymap !== 16'h0088) begin errors++; $display("FAIL release_early got=%h exp=0088", keymap); end
    run_to(545);
    checks++;
    if (keymap !== 16'h0000 || key_event !== 1'b0) begin
      errors++; $display("FAIL release got keymap=%h ev=%b exp=0000 0", keymap, key_event);
    end
    run_to(560);
    checks++;
    if (ev_cnt != 1 || key_index !== 4'd3) begin
      errors++; $display("FAIL two_event_count got=%0d idx=%0d exp=1 3", ev_cnt, key_index);
    end
  endtask

  task automatic test_reset_mid_scan();
    pressed = 16'h0040;
    restart();
    run_to(258);
    checks++;
    if (keymap !== 16'h0040) begin errors++; $display("FAIL mid_setup got=%h exp=0040", keymap); end
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (col !== 4'b1111 || keymap !== 16'h0000) begin
      errors++; $display("FAIL mid_reset got col=%b keymap=%h exp=1111 0000", col, keymap);
    end
    checks++;
    if (key_event !== 1'b0) begin errors++; $display("FAIL mid_reset_event got=%b exp=0", key_event); end
    @(posedge fpga_clk);
    #1;
    rst_in = 1'b1;
    n      = 0;
    ev_cnt = 0;
    checks++;
    if (col !== 4'b1111) begin errors++; $display("FAIL mid_idle_col got=%b exp=1111", col); end
    tick();
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL mid_restart_col got=%b exp=1110", col); end
    run_to(18);
    checks++;
    if (col !== 4'b1101) begin errors++; $display("FAIL mid_second_col got=%b exp=1101", col); end
  endtask

  task automatic test_remap();
    logic [15:0] exp_map;
    logic [3:0]  exp_idx;
`ifdef KEYPAD_REMAP_EN
    exp_map = 16'h0001;
    exp_idx = 4'd0;
`else
    exp_map = 16'h2000;
    exp_idx = 4'd13;
`endif
    pressed = 16'h2000;
    restart();
    run_to(238);
    checks++;
    if (keymap !== 16'h0000) begin errors++; $display("FAIL remap_early got=%h exp=0000", keymap); end
    run_to(239);
    checks++;
    if (keymap !== exp_map) begin errors++; $display("FAIL remap_keymap got=%h exp=%h", keymap, exp_map); end
    checks++;
    if (key_event !== 1'b1 || key_index !== exp_idx) begin
      errors++; $display("FAIL remap_event got ev=%b idx=%0d exp=1 %0d", key_event, key_index, exp_idx);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    n       = 0;
    ev_cnt  = 0;
    pressed = 16'h0000;
    rst_in  = 1'b1;
    test_reset();
    test_idle_scan();
    test_steady_press();
    test_bounce();
    test_two_keys();
    test_reset_mid_scan();
    test_remap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
